keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Front end that drives the microwave controller's keypad inputs from a physical 4x3 matrix keypad. It owns the transmitting end of the keypad, startn and stopn interface.
- Scans rows and reads columns, then debounces whole-matrix snapshots.
- Holds one-hot `keypad[9:0]` and active-low `startn`/`stopn` at levels for as long as the key is stably pressed. This matches the level-hold behaviour the controller expects.

Parameters:
- SCAN_DIV, 2, clock cycles each row is driven; columns are sampled on the last cycle of each row (settling time). Legal range is 1 or more.
- DEBOUNCE_SCANS, 3, number of consecutive identical full-matrix scans required before a result is committed. Legal range is 1 or more.

Ports:
- clk  input  1  system clock
- clear  input  1  reset, synchronous, active-high
- col_n  input  3  matrix columns, active-low (pulled up); col_n[c]=0 means the key at (driven row, c) is pressed
- row_n  output  4  matrix rows, active-low; exactly one bit is low except during the reset cycle
- keypad  output  10  one-hot digit; bit d=1 while digit d is committed
- startn  output  1  low while '#' is committed
- stopn  output  1  low while '*' is committed
- multi_key  output  1  high while the last completed scan saw two or more keys

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (clear).
- Key map (row, col):
  - r0: 1, 2, 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: *, 0, #
- Key codes: 0-9 are digits, 10 is *, 11 is #, 14 is MULTI, 15 is NONE.
- Reset, while clear=1 at a clock edge:
  - row_n=4'b1111, keypad=0, startn=1, stopn=1, multi_key=0.
  - Row index=0, divider=0, scan accumulator cleared, candidate=NONE, stable count=0, committed=NONE.
  - On the first edge with clear=0, row_n goes to 4'b1110.
  - clear mid-scan discards the partial scan; scanning restarts at row 0.
- Scan FSM:
  - States ROW0 -> ROW1 -> ROW2 -> ROW3 -> ROW0.
  - Each state lasts SCAN_DIV cycles; row_n = ~(4'b0001 << row).
  - On the sample cycle, every low col_n bit adds one to the press count and records its key code.
  - At the ROW3 sample the raw result is: count 0 -> NONE, count 1 -> that code, count 2 or more -> MULTI. The accumulator then clears.
  - Full scan length is 4*SCAN_DIV cycles.
- Debounce, evaluated once per completed scan:
  - If raw == candidate, stable count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise candidate=raw and count=1.
  - When count == DEBOUNCE_SCANS, committed=candidate, except that MULTI commits as NONE.
  - Otherwise committed holds its previous value: no glitch when sliding from key A to key B; A stays asserted until B has been stable.
- multi_key updates every scan to (raw == MULTI); it is not debounced.
- Outputs are registered from committed and update one cycle after the commit:
  - digit d: keypad=1<<d, startn=1, stopn=1
  - *: stopn=0, keypad=0
  - #: startn=0, keypad=0
  - NONE: idle (keypad=0, startn=1, stopn=1)
  - At most one of (keypad!=0, !startn, !stopn) is true at any time.
- Latency: a press that is stable from the start of scan k commits at the end of scan k+DEBOUNCE_SCANS-1; outputs change 1 cycle later. Release uses the same latency.
- A bounce shorter than one scan restarts the count; the output does not change.

Decomposition:
- microwave_pkg holds:
  - key code constants KEY_STAR=10, KEY_HASH=11, KEY_MULTI=14, KEY_NONE=15
  - key-map function (row, col) -> code
  - function code -> keypad one-hot
- One sub-module, keypad_debounce: raw code plus scan_done strobe in, committed code out; holds the candidate and saturating counter.
- keypad_scanner holds the scan FSM, the accumulator and the output encode.

Test Plan (bench models col_n combinationally from row_n and the set of pressed keys; defaults assumed, so a scan is 8 cycles and debounce takes 24 cycles):
- Reset: pulse clear 1 cycle -> row_n=1111 in that cycle, then 1110; keypad=0, startn=1, stopn=1. After 8 cycles row_n has cycled 1110, 1101, 1011, 0111 with 2 cycles each.
- Press '2' at a scan boundary and hold -> keypad=10'b0000000100 exactly 25 cycles later. Release -> keypad=0 25 cycles after the release boundary.
- Press '#' for 1 s, then '*' -> startn=0 and keypad=0 while held. Move directly to '*' -> startn stays 0 until '*' commits, then stopn=0 and startn=1 in the same cycle.
- Bounce: '9' pressed 1 scan, released 1 scan, pressed again steadily -> no output before 3 consecutive stable scans; then keypad=10'b1000000000.
- Multi: hold '5' until committed, then add '8' -> multi_key=1 from the next scan end; keypad falls to 0 after 3 MULTI scans; releasing '8' re-commits '5' 3 scans later.
- Reset mid-press: assert clear while '0' is committed -> outputs idle at the next edge; '0' re-commits 24+1 cycles after scanning restarts.

Source files
------------

// File: rtl/microwave_pkg.sv
// microwave_pkg: keypad code constants, scan states and key-map helpers
package microwave_pkg;
    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_HASH  = 4'd11;
    localparam logic [3:0] KEY_MULTI = 4'd14;
    localparam logic [3:0] KEY_NONE  = 4'd15;

    typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_t;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] base;
        base = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        return row != 2'd3 ? base : col == 2'd0 ? KEY_STAR : col == 2'd1 ? 4'd0 : KEY_HASH;
    endfunction

    function automatic logic [9:0] key_onehot(input logic [3:0] code);
        return code < 4'd10 ? 10'd1 << code : 10'd0;
    endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: commits a scan result once it repeats DEBOUNCE_SCANS times in a row
module keypad_debounce
    import microwave_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       scan_done,
    input  logic [3:0] raw,
    output logic [3:0] committed
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_SCANS);

    logic [3:0]    cand;
    logic [CW-1:0] cnt, cnt_nx;

    always_comb begin
        cnt_nx = raw == cand ? (cnt == CMAX ? CMAX : cnt + CW'(1)) : CW'(1);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cand      <= KEY_NONE;
            cnt       <= '0;
            committed <= KEY_NONE;
        end else if (scan_done) begin
            cand <= raw;
            cnt  <= cnt_nx;
            // a stable multi-press releases the output rather than holding the old key
            if (cnt_nx == CMAX) committed <= raw == KEY_MULTI ? KEY_NONE : raw;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x3 matrix keypad, debounces whole scans and drives
// level-held keypad/startn/stopn for the microwave controller
module keypad_scanner
    import microwave_pkg::*;
#(
    parameter int SCAN_DIV       = 2,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] keypad,
    output logic       startn,
    output logic       stopn,
    output logic       multi_key
);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;

    row_t          state, state_nx;
    logic          run;
    logic [DW-1:0] div;
    logic [1:0]    acc_cnt, hits;
    logic [3:0]    acc_code, code, raw, committed;
    logic          sample, scan_done;

    always_ff @(posedge clk) begin
        state <= clear ? ROW0 : state_nx;
    end

    // press count saturates at 2: anything beyond one key is simply MULTI
    always_comb begin
        sample = run && div == DW'(SCAN_DIV - 1);
        hits   = acc_cnt;
        code   = acc_code;
        for (int c = 0; c < 3; c++) begin
            if (sample && !col_n[c]) begin
                hits = hits == 2'd2 ? 2'd2 : hits + 2'd1;
                code = key_map(state, 2'(c));
            end
        end
        raw       = hits == 2'd0 ? KEY_NONE : hits == 2'd1 ? code : KEY_MULTI;
        scan_done = sample && state == ROW3;
        state_nx  = sample ? row_t'(state + 2'd1) : state;
    end

    assign row_n = run ? ~(4'b0001 << state) : 4'b1111;

    always_ff @(posedge clk) begin
        if (clear) begin
            run       <= 1'b0;
            div       <= '0;
            acc_cnt   <= 2'd0;
            acc_code  <= KEY_NONE;
            multi_key <= 1'b0;
            keypad    <= 10'd0;
            startn    <= 1'b1;
            stopn     <= 1'b1;
        end else begin
            run <= 1'b1;
            div <= sample ? '0 : div + DW'(run);
            if (sample) begin
                acc_cnt  <= scan_done ? 2'd0 : hits;
                acc_code <= scan_done ? KEY_NONE : code;
            end
            if (scan_done) multi_key <= raw == KEY_MULTI;
            keypad <= key_onehot(committed);
            startn <= committed != KEY_HASH;
            stopn  <= committed != KEY_STAR;
        end
    end

    keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .clk       (clk),
        .clear     (clear),
        .scan_done (scan_done),
        .raw       (raw),
        .committed (committed)
    );
endmodule
